// File: rtl/mem_access_sequencer.sv
// Data-memory access sequencer: turns a MEM-stage load/store into one or two
// req/ack word transactions, stalling the pipeline until the access completes.
module mem_access_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int WORD_STRIDE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_read,
    input  logic              req_write,
    input  logic              req_double,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata_lo,
    input  logic [DATA_W-1:0] req_wdata_hi,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata_lo,
    output logic [DATA_W-1:0] rdata_hi,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack
);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

    typedef struct packed {
        logic              store;
        logic              dbl;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wlo;
        logic [DATA_W-1:0] whi;
    } acc_t;

    state_t            state, state_nxt;
    acc_t              acc;
    logic              req_any;
    logic [ADDR_W-1:0] addr_hi;

    assign req_any = req_read | req_write;
    // Second word wraps naturally at the top of the address space.
    assign addr_hi = acc.addr + ADDR_W'(WORD_STRIDE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (state == IDLE && req_any) begin
            acc <= '{store: req_write, dbl: req_double, addr: req_addr,
                     wlo: req_wdata_lo, whi: req_wdata_hi};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_lo <= '0;
            rdata_hi <= '0;
        end else if (dm_ack && !acc.store) begin
            if (state == FIRST) begin
                rdata_lo <= dm_rdata;
                if (!acc.dbl) rdata_hi <= '0;
            end else if (state == SECOND) begin
                rdata_hi <= dm_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = acc.addr;
        dm_wdata  = acc.wlo;
        case (state)
            IDLE: begin
                stall = req_any;
                if (req_any) state_nxt = FIRST;
            end
            FIRST: begin
                stall  = 1'b1;
                dm_req = 1'b1;
                dm_we  = acc.store;
                if (dm_ack) state_nxt = acc.dbl ? SECOND : DONE;
            end
            SECOND: begin
                stall    = 1'b1;
                dm_req   = 1'b1;
                dm_we    = acc.store;
                dm_addr  = addr_hi;
                dm_wdata = acc.whi;
                if (dm_ack) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
